// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared unified memory port: fetch (port 0) and data (port 1).
// One access in flight; MEM_LAT BUSY cycles, then a single RESP cycle carrying the done pulse.
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic          we1,
    input  logic [DW-1:0] wd1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    generate
        if (MEM_LAT < 1) begin : g_lat_chk
            $error("mem_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic          last_q;
    logic          owner_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wd_q;
    logic [DW-1:0] rdata_q;

    logic is_idle;
    logic win0;
    logic win1;
    logic accept;
    logic last_beat;

    // On a tie the port that did not win last time goes first.
    assign is_idle   = (state_q == S_IDLE);
    assign win1      = req1 & (~req0 | ~last_q);
    assign win0      = req0 & ~win1;
    assign accept    = is_idle & (req0 | req1);
    assign last_beat = (state_q == S_BUSY) && (cnt_q == '0);

    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:  state_d = (req0 | req1) ? S_BUSY : S_IDLE;
            S_BUSY:  state_d = (cnt_q == '0) ? S_RESP : S_BUSY;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wd_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                owner_q <= win1;
                last_q  <= win1;
                cnt_q   <= CNT_INIT;
                addr_q  <= win1 ? addr1 : addr0;
                we_q    <= win1 & we1;
                // Fetches never write, so the write-data latch only follows port 1.
                if (win1) begin
                    wd_q <= wd1;
                end
            end else if (state_q == S_BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (last_beat && !we_q) begin
                rdata_q <= mem_rd;
            end
        end
    end

    // Gated with reset so strobes and grants drop the instant reset rises.
    assign gnt0     = is_idle & win0 & ~reset;
    assign gnt1     = is_idle & win1 & ~reset;
    assign done0    = (state_q == S_RESP) & ~owner_q & ~reset;
    assign done1    = (state_q == S_RESP) & owner_q & ~reset;
    assign busy     = ~is_idle & ~reset;
    assign mem_en   = (state_q == S_BUSY) & ~reset;
    assign mem_we   = last_beat & we_q & ~reset;
    assign mem_addr = addr_q;
    assign mem_wd   = wd_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances at MEM_LAT = 1, 2, 3 share stimulus.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we1;
    logic [7:0] addr0, addr1, wd1, mem_rd;

    logic [2:0] g0, g1, d0, d1, bz, en, we;
    logic [7:0] rd [3];
    logic [7:0] ma [3];
    logic [7:0] mw [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_dut
            mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(i + 1)) u_dut (
                .clk      (clk),
                .reset    (reset),
                .req0     (req0),
                .addr0    (addr0),
                .req1     (req1),
                .addr1    (addr1),
                .we1      (we1),
                .wd1      (wd1),
                .gnt0     (g0[i]),
                .gnt1     (g1[i]),
                .done0    (d0[i]),
                .done1    (d1[i]),
                .rdata    (rd[i]),
                .busy     (bz[i]),
                .mem_en   (en[i]),
                .mem_we   (we[i]),
                .mem_addr (ma[i]),
                .mem_wd   (mw[i]),
                .mem_rd   (mem_rd)
            );
        end
    endgenerate

    // ctl bit order: {gnt0, gnt1, done0, done1, busy, mem_en, mem_we}
    typedef struct {
        logic       r0;
        logic [7:0] a0;
        logic       r1;
        logic [7:0] a1;
        logic       w1;
        logic [7:0] wd;
        logic [7:0] mrd;
        logic [6:0] ctl;
        logic [7:0] rdat;
        logic [7:0] addr;
        logic       chk_wd;
        logic [7:0] wdat;
    } vec_t;

    vec_t tbl_a [18];
    vec_t tbl_b [6];

    function automatic vec_t mk(input logic r0, input logic [7:0] a0, input logic r1,
                                input logic [7:0] a1, input logic w1, input logic [7:0] wd,
                                input logic [7:0] mrd, input logic [6:0] ctl,
                                input logic [7:0] rdat, input logic [7:0] addr,
                                input logic chk_wd, input logic [7:0] wdat);
        vec_t v;
        v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1; v.w1 = w1; v.wd = wd; v.mrd = mrd;
        v.ctl = ctl; v.rdat = rdat; v.addr = addr; v.chk_wd = chk_wd; v.wdat = wdat;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_of(input int i);
        return {g0[i], g1[i], d0[i], d1[i], bz[i], en[i], we[i]};
    endfunction

    task automatic drive(input logic r0, input logic [7:0] a0, input logic r1,
                         input logic [7:0] a1, input logic w1, input logic [7:0] wd);
        req0 = r0; addr0 = a0; req1 = r1; addr1 = a1; we1 = w1; wd1 = wd;
    endtask

    // Leaves the bench at posedge+1 with reset released: start of cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00);
        mem_rd = 8'h00;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_ctl[%0d]", i), 32'(ctl_of(i)), 32'h0);
            chk($sformatf("reset_data[%0d]", i), {8'h0, rd[i], ma[i], mw[i]}, 32'h0);
        end
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx, input string name);
        drive(v.r0, v.a0, v.r1, v.a1, v.w1, v.wd);
        mem_rd = v.mrd;
        @(negedge clk);
        chk({name, " ctl"}, 32'(ctl_of(idx)), 32'(v.ctl));
        chk({name, " rdata"}, 32'(rd[idx]), 32'(v.rdat));
        chk({name, " mem_addr"}, 32'(ma[idx]), 32'(v.addr));
        if (v.chk_wd) chk({name, " mem_wd"}, 32'(mw[idx]), 32'(v.wdat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // MEM_LAT=2: fetch read, data read dropped in BUSY, tie-break both ways, data write.
        tbl_a[0]  = mk(1, 8'h10, 0, 8'h00, 0, 8'h00, 8'hA5, 7'b1000000, 8'h00, 8'h00, 1, 8'h00);
        tbl_a[1]  = mk(0, 8'h10, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0000110, 8'h00, 8'h10, 0, 8'h00);
        tbl_a[2]  = mk(0, 8'h10, 0, 8'h00, 0, 8'h00, 8'hA5, 7'b0000110, 8'h00, 8'h10, 0, 8'h00);
        tbl_a[3]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 7'b0010100, 8'hA5, 8'h10, 0, 8'h00);
        tbl_a[4]  = mk(0, 8'h00, 1, 8'h33, 0, 8'h00, 8'h00, 7'b0100000, 8'hA5, 8'h10, 0, 8'h00);
        tbl_a[5]  = mk(0, 8'h00, 0, 8'h33, 0, 8'h00, 8'hEE, 7'b0000110, 8'hA5, 8'h33, 0, 8'h00);
        tbl_a[6]  = mk(0, 8'h00, 0, 8'h33, 0, 8'h00, 8'h5A, 7'b0000110, 8'hA5, 8'h33, 0, 8'h00);
        tbl_a[7]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 7'b0001100, 8'h5A, 8'h33, 0, 8'h00);
        tbl_a[8]  = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'h33, 0, 8'h00);
        tbl_a[9]  = mk(1, 8'h44, 1, 8'h55, 1, 8'h77, 8'h00, 7'b1000000, 8'h5A, 8'h33, 0, 8'h00);
        tbl_a[10] = mk(1, 8'h44, 1, 8'h55, 1, 8'h77, 8'hEE, 7'b0000110, 8'h5A, 8'h44, 0, 8'h00);
        tbl_a[11] = mk(1, 8'h44, 1, 8'h55, 1, 8'h77, 8'h99, 7'b0000110, 8'h5A, 8'h44, 0, 8'h00);
        tbl_a[12] = mk(1, 8'h44, 1, 8'h55, 1, 8'h77, 8'h00, 7'b0010100, 8'h99, 8'h44, 0, 8'h00);
        tbl_a[13] = mk(1, 8'h44, 1, 8'h55, 1, 8'h77, 8'h00, 7'b0100000, 8'h99, 8'h44, 0, 8'h00);
        tbl_a[14] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h11, 7'b0000110, 8'h99, 8'h55, 1, 8'h77);
        tbl_a[15] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h11, 7'b0000111, 8'h99, 8'h55, 1, 8'h77);
        tbl_a[16] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h11, 7'b0001100, 8'h99, 8'h55, 1, 8'h77);
        tbl_a[17] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'h00, 7'b0000000, 8'h99, 8'h55, 1, 8'h77);
        // MEM_LAT=3: single data write, strobe only in the third BUSY cycle.
        tbl_b[0] = mk(0, 8'h00, 1, 8'h20, 1, 8'h3C, 8'hEE, 7'b0100000, 8'h00, 8'h00, 1, 8'h00);
        tbl_b[1] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0000110, 8'h00, 8'h20, 1, 8'h3C);
        tbl_b[2] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0000110, 8'h00, 8'h20, 1, 8'h3C);
        tbl_b[3] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0000111, 8'h00, 8'h20, 1, 8'h3C);
        tbl_b[4] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0001100, 8'h00, 8'h20, 1, 8'h3C);
        tbl_b[5] = mk(0, 8'h00, 0, 8'h00, 0, 8'h00, 8'hEE, 7'b0000000, 8'h00, 8'h20, 1, 8'h3C);

        do_reset();
        for (int k = 0; k < 18; k++) run_vec(tbl_a[k], 1, $sformatf("lat2_row%0d", k));

        do_reset();
        for (int k = 0; k < 6; k++) run_vec(tbl_b[k], 2, $sformatf("lat3_wr_row%0d", k));

        // Both ports held: grants alternate 0,1,0,1 every MEM_LAT+2 = 4 cycles.
        do_reset();
        drive(1'b1, 8'h01, 1'b1, 8'h02, 1'b0, 8'h00);
        for (int k = 0; k < 16; k++) begin
            logic p;
            logic [3:0] exp;
            p = ((k / 4) % 2) == 1;
            exp = {(k % 4 == 0) && !p, (k % 4 == 0) && p, (k % 4 == 3) && !p, (k % 4 == 3) && p};
            @(negedge clk);
            chk($sformatf("rr_cyc%0d", k), {28'h0, g0[1], g1[1], d0[1], d1[1]}, {28'h0, exp});
            @(posedge clk);
            #1;
        end

        // Async reset mid-access drops strobes before the next edge; first tie goes to port 0.
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h66, 1'b1, 8'h12);
        @(posedge clk);
        #1;
        chk("arst_pre lat1 en/we", {30'h0, en[0], we[0]}, 32'h3);
        chk("arst_pre lat2 en/busy", {30'h0, en[1], bz[1]}, 32'h3);
        #2;
        reset = 1'b1;
        drive(1'b1, 8'h07, 1'b1, 8'h08, 1'b0, 8'h00);
        #1;
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_drop[%0d]", i), {29'h0, en[i], we[i], bz[i]}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("arst_regrant[%0d]", i), {28'h0, g0[i], g1[i], d0[i], d1[i]}, 32'h8);
        @(posedge clk);
        #1;

        // MEM_LAT=1, fetch held: grant and done each every 3 cycles, never back to back.
        do_reset();
        drive(1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk($sformatf("lat1_fetch_cyc%0d", k), {30'h0, g0[0], d0[0]},
                {30'h0, k % 3 == 0, k % 3 == 2});
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
